// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing and playfield geometry for the scanner and its consumers.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_TOT  = 800;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_TOT  = 525;

  localparam int FIELD_X0 = 320;
  localparam int CELL     = 20;
  localparam int COLS     = 10;
  localparam int ROWS     = 22;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_grid_scanner_if.sv
// Pixel-coordinate bus from the scanner to the grid and sprite mappers.
interface vga_grid_scanner_if;

  logic            pix_tick;
  vga_pkg::coord_t DrawX;
  vga_pkg::coord_t DrawY;
  logic            hs;
  logic            vs;
  logic            de;
  logic            in_field;
  logic [3:0]      cell_col;
  logic [4:0]      cell_row;
  logic            grid_line;
  logic            frame_end;

  modport master (
    output pix_tick, DrawX, DrawY, hs, vs, de,
           in_field, cell_col, cell_row, grid_line, frame_end
  );

  modport slave (
    input  pix_tick, DrawX, DrawY, hs, vs, de,
           in_field, cell_col, cell_row, grid_line, frame_end
  );

endinterface

// File: rtl/vga_grid_scanner_wrap.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the terminal count.
module wrap_counter #(
  parameter int MAX   = 1,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] q_q, q_d;

  assign wrap = (q_q == WIDTH'(MAX));
  assign q    = q_q;

  // NOTE: default assignment first so every path drives q_d and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = wrap ? '0 : q_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignment so all flops sample their inputs from the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/vga_grid_scanner.sv
// 640x480@60 scan generator with incremental 10x22 playfield cell tracking;
// every decode is taken from registered state so it lines up with DrawX/DrawY.
module vga_grid_scanner #(
  parameter int CLK_DIV  = 2,
  parameter int FIELD_X0 = vga_pkg::FIELD_X0,
  parameter int CELL     = vga_pkg::CELL,
  parameter int COLS     = vga_pkg::COLS,
  parameter int ROWS     = vga_pkg::ROWS
) (
  input  logic                Clk,
  input  logic                Reset,
  vga_grid_scanner_if.master  vga
);

  typedef vga_pkg::coord_t coord_t;

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW     = $clog2(CELL);
  localparam int XC_OFS = FIELD_X0 / CELL;
  localparam int XC_MAX = XC_OFS + COLS;
  localparam int YC_MAX = ROWS;
  localparam int XCW    = $clog2(XC_MAX + 1);
  localparam int YCW    = $clog2(YC_MAX + 1);

  localparam coord_t H_VIS_C = coord_t'(vga_pkg::H_VIS);
  localparam coord_t V_VIS_C = coord_t'(vga_pkg::V_VIS);
  localparam coord_t HS_LO   = coord_t'(vga_pkg::H_VIS + vga_pkg::H_FP);
  localparam coord_t HS_HI   = coord_t'(vga_pkg::H_VIS + vga_pkg::H_FP + vga_pkg::H_SYNC);
  localparam coord_t VS_LO   = coord_t'(vga_pkg::V_VIS + vga_pkg::V_FP);
  localparam coord_t VS_HI   = coord_t'(vga_pkg::V_VIS + vga_pkg::V_FP + vga_pkg::V_SYNC);
  localparam coord_t X_LO    = coord_t'(FIELD_X0);
  localparam coord_t X_HI    = coord_t'(FIELD_X0 + COLS * CELL);
  localparam coord_t Y_HI    = coord_t'(ROWS * CELL);

  logic [DIV_W-1:0] div_q, div_d;
  logic             adv, line_adv, frame_adv;

  coord_t           h_cnt, v_cnt, h_nxt, v_nxt;
  logic             h_end, v_end;
  logic [CW-1:0]    xm_cnt, ym_cnt;
  logic             xm_end, ym_end;
  logic [XCW-1:0]   xc_q, xc_d;
  logic [YCW-1:0]   yc_q, yc_d;

  logic             hs_q, hs_d, vs_q, vs_d;
  logic             pix_tick_q, frame_end_q;
  logic             in_field;

  assign adv       = (div_q == DIV_W'(CLK_DIV - 1));
  assign line_adv  = adv & h_end;
  assign frame_adv = line_adv & v_end;

  always_comb begin
    div_d = adv ? '0 : div_q + 1'b1;
  end

  wrap_counter #(.MAX(vga_pkg::H_TOT - 1), .WIDTH(10)) u_h (
    .Clk(Clk), .Reset(Reset), .en(adv), .clr(1'b0), .q(h_cnt), .wrap(h_end)
  );

  wrap_counter #(.MAX(vga_pkg::V_TOT - 1), .WIDTH(10)) u_v (
    .Clk(Clk), .Reset(Reset), .en(line_adv), .clr(1'b0), .q(v_cnt), .wrap(v_end)
  );

  wrap_counter #(.MAX(CELL - 1), .WIDTH(CW)) u_xm (
    .Clk(Clk), .Reset(Reset), .en(adv), .clr(line_adv), .q(xm_cnt), .wrap(xm_end)
  );

  // V_TOT is not a multiple of CELL, so ym needs an explicit clear at frame wrap.
  wrap_counter #(.MAX(CELL - 1), .WIDTH(CW)) u_ym (
    .Clk(Clk), .Reset(Reset), .en(line_adv), .clr(frame_adv), .q(ym_cnt), .wrap(ym_end)
  );

  // Cell counters stop at the first cell past the field, which is all the decode needs.
  always_comb begin
    xc_d = xc_q;
    if (line_adv) begin
      xc_d = '0;
    end else if (adv && xm_end && (xc_q != XCW'(XC_MAX))) begin
      xc_d = xc_q + 1'b1;
    end
  end

  always_comb begin
    yc_d = yc_q;
    if (frame_adv) begin
      yc_d = '0;
    end else if (line_adv && ym_end && (yc_q != YCW'(YC_MAX))) begin
      yc_d = yc_q + 1'b1;
    end
  end

  // Syncs are decoded from the coordinate about to be loaded so they switch with it.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (adv) begin
      h_nxt = h_end ? '0 : h_cnt + 1'b1;
    end
    if (frame_adv) begin
      v_nxt = '0;
    end else if (line_adv) begin
      v_nxt = v_cnt + 1'b1;
    end
    hs_d = !((h_nxt >= HS_LO) && (h_nxt < HS_HI));
    vs_d = !((v_nxt >= VS_LO) && (v_nxt < VS_HI));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q       <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      pix_tick_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      pix_tick_q  <= adv;
      frame_end_q <= frame_adv;
    end
  end

  assign in_field = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt < Y_HI);

  assign vga.pix_tick  = pix_tick_q;
  assign vga.frame_end = frame_end_q;
  assign vga.DrawX     = h_cnt;
  assign vga.DrawY     = v_cnt;
  assign vga.hs        = hs_q;
  assign vga.vs        = vs_q;
  assign vga.de        = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign vga.in_field  = in_field;
  assign vga.cell_col  = in_field ? 4'(xc_q - XCW'(XC_OFS)) : 4'd0;
  assign vga.cell_row  = in_field ? 5'(yc_q) : 5'd0;
  assign vga.grid_line = (h_cnt >= X_LO) && (h_cnt <= X_HI) && (v_cnt <= Y_HI) &&
                         ((xm_cnt == '0) || (ym_cnt == '0));

endmodule

// File: doc/vga_grid_scanner.md
# vga_grid_scanner

- Sequential source of the pixel-coordinate interface that the grid and sprite mappers consume.
- Generates 640x480@60 VGA timing from the 50 MHz system clock and drives DrawX/DrawY, hs/vs and display enable.
- Also tracks cell coordinates for the 10x22 playfield incrementally, so downstream blocks need no `%20` or `/20` hardware.
- grid_line is bit-exact with the playfield grid-line rule, so the existing combinational grid mapper can be swapped for this output.

## Interface
Parameters:
- CLK_DIV, 2, Clk cycles per pixel; pix_tick rate = Clk/CLK_DIV.
- FIELD_X0, 320, first playfield pixel column.
- CELL, 20, cell edge in pixels.
- COLS, 10, playfield columns.
- ROWS, 22, playfield rows.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- pix_tick  out  1  one-Clk strobe, every CLK_DIV cycles; all pixel state advances only on it.
- DrawX  out  10  current column, 0..799.
- DrawY  out  10  current line, 0..524.
- hs  out  1  horizontal sync, active-low, registered.
- vs  out  1  vertical sync, active-low, registered.
- de  out  1  display enable: DrawX<640 && DrawY<480.
- in_field  out  1  FIELD_X0<=DrawX<FIELD_X0+COLS*CELL && DrawY<ROWS*CELL.
- cell_col  out  4  (DrawX-FIELD_X0)/CELL when in_field, else 0.
- cell_row  out  5  DrawY/CELL when in_field, else 0.
- grid_line  out  1  FIELD_X0<=DrawX<=FIELD_X0+COLS*CELL && DrawY<=ROWS*CELL && (DrawX%CELL==0 || DrawY%CELL==0).
- frame_end  out  1  one-Clk pulse on the pix_tick that advances (799,524) to (0,0).

## Operation
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Registered state:
  - h and v counters, driving DrawX and DrawY.
  - xm counter, 0..CELL-1: cleared at h=0 and wraps every CELL pixels, so xm==DrawX%CELL.
  - ym counter, 0..CELL-1: cleared at v=0, advances once per line on the h wrap, so ym==DrawY%CELL.
  - xc, yc: whole-frame cell counters, incremented when xm and ym wrap respectively.
  - hs, vs.
- hs and vs are computed from the next h/v values, so they change in the same Clk edge as DrawX/DrawY. They never lag by a pixel.
- de, in_field, cell_col, cell_row and grid_line are combinational decodes of registered state only. No external input reaches them.
- cell_col = xc - FIELD_X0/CELL, using FIELD_X0%CELL==0. cell_row = yc.
- Width rule: xc and yc saturate at their maximum field-relevant value, so they never overflow.
- Wrap-around: h 799→0 increments v; v 524→0 on the same tick. xm, xc, ym and yc all clear consistently.

## Timing
- Reset values:
  - DrawX=0, DrawY=0, xm=ym=0.
  - hs=1, vs=1, pix_tick=0, frame_end=0.
  - Derived outputs: de=1, in_field=0, grid_line=0, cell_col=0, cell_row=0.
- First pix_tick: CLK_DIV Clk cycles after Reset deasserts. The first advance (0,0)→(1,0) happens on that edge.
- Latency: every output is valid in the same Clk cycle in which DrawX/DrawY show the pixel. There is zero pipeline offset between coordinate and decode.
- Between ticks, all outputs hold.
- Reset asserted mid-line or mid-frame: all outputs return to reset values asynchronously. Scanning restarts from (0,0) with a fresh divider phase, and no partial pix_tick is emitted.
- frame_end and pix_tick are both single-Clk-cycle pulses. frame_end is always coincident with a pix_tick.

## Structure
- Package vga_pkg holds:
  - H_VIS, H_FP, H_SYNC, H_TOT, V_VIS, V_FP, V_SYNC, V_TOT;
  - the field constants FIELD_X0, CELL, COLS, ROWS;
  - typedef coord_t (logic [9:0]).
- One sub-module, wrap_counter (params MAX, WIDTH; ports Clk, Reset, en, clr; outputs q, wrap). Instantiate it for h, v, xm and ym.
- The divider and the hs/vs flops live in the top.

## Test plan
- Reset release, count 800*525*CLK_DIV Clk cycles: exactly one frame_end, and 420000 pix_ticks with CLK_DIV=2.
- Line timing: hs low for exactly 96 ticks, starting the tick DrawX becomes 656. Frame timing: vs low for lines 490..491 only. de high for 640 ticks per visible line.
- Cell mapping at DrawX=339,340,519,520 on DrawY=39,40:
  - cell_col=0,1,9,0.
  - in_field=1,1,1,0.
  - cell_row=1 at Y=39 and 2 at Y=40.
- Exhaustive full-frame compare: grid_line equals the modulo reference expression for every (DrawX,DrawY). This checks grid_line=1 at (520,100) and (400,440), and 0 at (520,441) and (319,0).
- Reset asserted at DrawX=437, DrawY=212 mid-tick: the same Clk cycle shows DrawX=0, DrawY=0, hs=vs=1. After release, the first tick arrives CLK_DIV cycles later.
- Wrap: at (799,524) the next tick gives (0,0), xm=ym=0 and frame_end=1 for one Clk only.
